// File: rtl/mdu_ctrl.sv
// Sequencing controller for the E-stage multiply/divide unit and the HI/LO registers.
// Results are computed at accept time and committed after a fixed countdown.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUop,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        Req,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic              pend_we_q, pend_we_d;

    logic              start;
    logic [63:0]       prod_s, prod_u;
    logic [31:0]       abs_a, abs_b, div_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic              div_zero;

    // Sign-extended 64-bit product truncated to 64 bits equals the signed product.
    always_comb begin
        prod_s = {{32{D1[31]}}, D1} * {{32{D2[31]}}, D2};
        prod_u = {32'd0, D1} * {32'd0, D2};
    end

    // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly.
    always_comb begin
        div_zero = (D2 == 32'd0);
        abs_a    = D1[31] ? (~D1 + 32'd1) : D1;
        abs_b    = D2[31] ? (~D2 + 32'd1) : D2;
        div_b    = div_zero ? 32'd1 : abs_b;
        q_mag    = abs_a / div_b;
        r_mag    = abs_a % div_b;
        q_s      = (D1[31] ^ D2[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s      = D1[31] ? (~r_mag + 32'd1) : r_mag;
        q_u      = D1 / (div_zero ? 32'd1 : D2);
        r_u      = D1 % (div_zero ? 32'd1 : D2);
    end

    always_comb begin
        start = (state_q == StIdle) && !Req && (MDUop inside {OpMult, OpMultu, OpDiv, OpDivu});
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    busy_d  = 1'b1;
                    case (MDUop)
                        OpMult: begin
                            cnt_d     = CntW'(MULT_CYCLES);
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_we_d = 1'b1;
                        end
                        OpMultu: begin
                            cnt_d     = CntW'(MULT_CYCLES);
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_we_d = 1'b1;
                        end
                        OpDiv: begin
                            cnt_d     = CntW'(DIV_CYCLES);
                            pend_hi_d = r_s;
                            pend_lo_d = q_s;
                            pend_we_d = !div_zero;
                        end
                        default: begin
                            cnt_d     = CntW'(DIV_CYCLES);
                            pend_hi_d = r_u;
                            pend_lo_d = q_u;
                            pend_we_d = !div_zero;
                        end
                    endcase
                end else if (!Req && MDUop == OpMthi) begin
                    hi_d = D1;
                end else if (!Req && MDUop == OpMtlo) begin
                    lo_d = D1;
                end
            end
            StRun: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign Start = start;
    assign Busy  = busy_q;
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule
